// File: rtl/disp_pkg.sv
// Shared display definitions: glyph codes, digit count and the formatter state encoding.
// Also consumed by the segment driver, so glyph values must stay stable.
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int GLYPH_W    = 5;

  localparam logic [GLYPH_W-1:0] CODE_MINUS = 5'd12;
  localparam logic [GLYPH_W-1:0] CODE_E     = 5'd15;
  localparam logic [GLYPH_W-1:0] CODE_BLANK = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CONV = 2'd2,
    ST_FMT  = 2'd3
  } fmt_state_e;

  // BCD digits 0-9 map directly onto their glyph codes.
  function automatic logic [GLYPH_W-1:0] digit_code(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 (double-dabble) converter, one input bit per clock.
// Handshake: start_i is accepted only while busy_o=0; done_o is high during the final shift cycle and bcd_o is valid from the next cycle until the next start.
module bin2bcd_seq #(
  parameter int BIN_W = 28,
  parameter int BCD_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        bin_q  <= bin_i;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end else begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/disp_formatter.sv
// Turns a signed binary value into eight glyph codes with leading-zero blanking,
// minus sign, decimal point and an error display for overflow or calculator errors.
module disp_formatter #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  err_in,
  input  logic [2:0]            dp_idx,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            seg_data_1,
  output logic [4:0]            seg_data_2,
  output logic [4:0]            seg_data_3,
  output logic [4:0]            seg_data_4,
  output logic [4:0]            seg_data_5,
  output logic [4:0]            seg_data_6,
  output logic [4:0]            seg_data_7,
  output logic [4:0]            seg_data_8,
  output logic [NUM_DIGITS-1:0] seg_data_en,
  output logic [NUM_DIGITS-1:0] seg_dot_en,
  output logic [1:0]            dbg_state
);
  import disp_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [BIN_W-1:0] MAX_POS = BIN_W'(99_999_999);
  localparam logic [BIN_W-1:0] MAX_NEG = BIN_W'(9_999_999);

  fmt_state_e           state_q;
  logic [BIN_W-1:0]     value_q;
  logic                 err_q;
  logic [2:0]           dp_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 busy_q;
  logic                 done_q;
  logic [4:0]           seg_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] en_q;
  logic [NUM_DIGITS-1:0] dot_q;

  logic [BIN_W-1:0]     mag_c;
  logic                 ovf_c;
  logic                 eng_start;
  logic                 eng_busy;
  logic                 eng_done;
  logic [BCD_W-1:0]     eng_bcd;

  logic [4:0]           fmt_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] fmt_en;
  logic [NUM_DIGITS-1:0] fmt_dot;

  // The negative limit is one digit shorter because the minus sign needs a digit of its own.
  always_comb begin
    mag_c = value_q[BIN_W-1] ? (~value_q + 1'b1) : value_q;
    ovf_c = value_q[BIN_W-1] ? (mag_c > MAX_NEG) : (mag_c > MAX_POS);
  end

  assign eng_start = (state_q == ST_PREP) && !eng_busy;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (eng_start),
    .bin_i   (mag_c),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_comb begin
    int   msd;
    logic nz_left;
    msd     = 0;
    nz_left = 1'b0;
    fmt_en  = '0;
    fmt_dot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      fmt_seg[i] = CODE_BLANK;
    end
    if (err_q || ovf_q) begin
      fmt_seg[0] = CODE_E;
      fmt_en[0]  = 1'b1;
    end else begin
      // Kept digits form a contiguous run from digit 1 up to the most significant shown digit.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        nz_left = nz_left || (eng_bcd[4*i +: 4] != 4'd0);
        if (nz_left || (i == 0) || (i <= int'(dp_q))) begin
          fmt_seg[i] = digit_code(eng_bcd[4*i +: 4]);
          fmt_en[i]  = 1'b1;
        end
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (fmt_en[i]) msd = i;
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (neg_q && (eng_bcd != '0) && (i == msd + 1)) begin
          fmt_seg[i] = CODE_MINUS;
          fmt_en[i]  = 1'b1;
        end
        if ((dp_q != 3'd0) && (i == int'(dp_q))) begin
          fmt_dot[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      err_q   <= 1'b0;
      dp_q    <= 3'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      dot_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_q[i] <= CODE_BLANK;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            value_q <= value_in;
            err_q   <= err_in;
            dp_q    <= dp_idx;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          neg_q   <= value_q[BIN_W-1];
          ovf_q   <= ovf_c;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (eng_done) state_q <= ST_FMT;
        end
        ST_FMT: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_q[i] <= fmt_seg[i];
          end
          en_q    <= fmt_en;
          dot_q   <= fmt_dot;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign seg_data_1  = seg_q[0];
  assign seg_data_2  = seg_q[1];
  assign seg_data_3  = seg_q[2];
  assign seg_data_4  = seg_q[3];
  assign seg_data_5  = seg_q[4];
  assign seg_data_6  = seg_q[5];
  assign seg_data_7  = seg_q[6];
  assign seg_data_8  = seg_q[7];
  assign seg_data_en = en_q;
  assign seg_dot_en  = dot_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_disp_formatter.sv
// Directed bench for disp_formatter: latency, blanking, sign, decimal point, error, busy and reset behaviour.
module tb_disp_formatter;

  localparam logic [4:0] B = 5'd16;
  localparam logic [4:0] M = 5'd12;
  localparam logic [4:0] E = 5'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [27:0] value_in;
  logic        err_in;
  logic [2:0]  dp_idx;
  logic        busy;
  logic        done;
  logic [4:0]  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8;
  logic [7:0]  seg_en;
  logic [7:0]  dot_en;
  logic [1:0]  dbg_state;
  logic [39:0] seg_obs;

  int checks   = 0;
  int failures = 0;
  logic [55:0] exp_q[$];

  always #5 clk = ~clk;

  disp_formatter dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value_in    (value_in),
    .err_in      (err_in),
    .dp_idx      (dp_idx),
    .busy        (busy),
    .done        (done),
    .seg_data_1  (seg1),
    .seg_data_2  (seg2),
    .seg_data_3  (seg3),
    .seg_data_4  (seg4),
    .seg_data_5  (seg5),
    .seg_data_6  (seg6),
    .seg_data_7  (seg7),
    .seg_data_8  (seg8),
    .seg_data_en (seg_en),
    .seg_dot_en  (dot_en),
    .dbg_state   (dbg_state)
  );

  assign seg_obs = {seg8, seg7, seg6, seg5, seg4, seg3, seg2, seg1};

  function automatic logic [39:0] segs(input logic [4:0] s8, s7, s6, s5, s4, s3, s2, s1);
    return {s8, s7, s6, s5, s4, s3, s2, s1};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic score(input string tag);
    logic [55:0] e;
    e = exp_q.pop_front();
    check({tag, "_seg"}, 64'(seg_obs), 64'(e[55:16]));
    check({tag, "_en"},  64'(seg_en),  64'(e[15:8]));
    check({tag, "_dot"}, 64'(dot_en),  64'(e[7:0]));
  endtask

  // Issue one request and wait (bounded) for its done pulse.
  task automatic run_req(input string tag, input logic [27:0] val, input logic err,
                         input logic [2:0] dp, input logic [55:0] exp);
    int cyc;
    exp_q.push_back(exp);
    @(negedge clk);
    load = 1'b1; value_in = val; err_in = err; dp_idx = dp;
    @(negedge clk);
    load = 1'b0;
    cyc = 1;
    check({tag, "_busy1"}, 64'(busy), 64'(1));
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(31));
    if (done) begin
      check({tag, "_busy_end"}, 64'(busy), 64'(0));
      score(tag);
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [55:0] err_exp;
    int ndone;
    int first_cyc;
    err_exp = {segs(B, B, B, B, B, B, B, E), 8'h01, 8'h00};

    rst = 1'b1; load = 1'b0; value_in = '0; err_in = 1'b0; dp_idx = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_seg",   64'(seg_obs),   64'(segs(B, B, B, B, B, B, B, B)));
    check("rst_en",    64'(seg_en),    64'(0));
    check("rst_dot",   64'(dot_en),    64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    run_req("full", 28'd12345678, 1'b0, 3'd0, {segs(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 8'h00});
    run_req("neg42", 28'(-42), 1'b0, 3'd0, {segs(B, B, B, B, B, M, 4, 2), 8'h07, 8'h00});
    run_req("dp2", 28'd5, 1'b0, 3'd2, {segs(B, B, B, B, B, 0, 0, 5), 8'h07, 8'h04});
    run_req("ovf_pos", 28'd100000000, 1'b0, 3'd0, err_exp);
    run_req("ovf_neg", 28'(-10000000), 1'b0, 3'd0, err_exp);
    run_req("err_in", 28'd7, 1'b1, 3'd3, err_exp);
    run_req("min_neg", 28'h8000000, 1'b0, 3'd0, err_exp);
    run_req("max_pos", 28'd99999999, 1'b0, 3'd0, {segs(9, 9, 9, 9, 9, 9, 9, 9), 8'hFF, 8'h00});
    run_req("max_neg", 28'(-9999999), 1'b0, 3'd0, {segs(M, 9, 9, 9, 9, 9, 9, 9), 8'hFF, 8'h00});
    run_req("zero_dp3", 28'd0, 1'b0, 3'd3, {segs(B, B, B, B, 0, 0, 0, 0), 8'h0F, 8'h08});
    run_req("neg_dp3", 28'(-5), 1'b0, 3'd3, {segs(B, B, B, M, 0, 0, 0, 5), 8'h1F, 8'h08});

    // Second load while busy must be dropped.
    exp_q.push_back({segs(B, B, B, B, B, 3, 2, 1), 8'h07, 8'h00});
    @(negedge clk);
    load = 1'b1; value_in = 28'd321; err_in = 1'b0; dp_idx = 3'd0;
    @(negedge clk);
    ndone = 0;
    first_cyc = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_cyc = cyc;
          score("busy_ign");
        end
      end
      if (cyc == 5) begin
        load = 1'b1; value_in = 28'd999;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_ign_ndone", 64'(ndone), 64'(1));
    check("busy_ign_cyc", 64'(first_cyc), 64'(31));
    if (ndone == 0) void'(exp_q.pop_front());

    // Reset during CONV abandons the conversion.
    @(negedge clk);
    load = 1'b1; value_in = 28'd55;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("mid_rst_ndone", 64'(ndone), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_seg", 64'(seg_obs), 64'(segs(B, B, B, B, B, B, B, B)));
    check("mid_rst_en", 64'(seg_en), 64'(0));
    check("mid_rst_dot", 64'(dot_en), 64'(0));

    // Reset wins over a simultaneous load.
    rst = 1'b1; load = 1'b1; value_in = 28'd77;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    check("rst_load_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("rst_load_state", 64'(dbg_state), 64'(0));

    run_req("zero", 28'd0, 1'b0, 3'd0, {segs(B, B, B, B, B, B, B, 0), 8'h01, 8'h00});

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_formatter.md
DISP_FORMATTER -- requirements
Module: disp_formatter

Interface
REQ-001 Parameter NUM_DIGITS, default 8: digit count; fixed at 8 for this release.
REQ-002 Parameter BIN_W, default 28: width of the signed input value.
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  single-cycle request to format value_in, err_in and dp_idx.
REQ-006 value_in  input  28  signed two's-complement number to display.
REQ-007 err_in  input  1  calculator error flag; forces the error display.
REQ-008 dp_idx  input  3  decimal point position: 0 = none, n = 1..7 = dot on digit n+1 (n fractional digits).
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when the display outputs have been updated.
REQ-011 seg_data_1 .. seg_data_8  output  5 each  glyph codes; seg_data_1 is the rightmost digit.
REQ-012 seg_data_en  output  8  per-digit enable, bit0 = seg_data_1.
REQ-013 seg_dot_en  output  8  per-digit decimal point enable, bit0 = seg_data_1.

Function
REQ-014 Glyph codes SHALL be: 0-9 for the digits, 12 for minus, 15 for E, and 16 for blank.
REQ-015 FSM states SHALL be IDLE, PREP, CONV and FMT.
REQ-016 In IDLE with load=1, the block SHALL capture the inputs, set busy=1 on the next edge and enter PREP.
REQ-017 load while busy=1 SHALL be ignored, with no queuing.
REQ-018 PREP (1 cycle) SHALL compute the 28-bit unsigned magnitude and the sign.
REQ-019 PREP SHALL flag overflow when either holds: positive magnitude > 99,999,999; or negative magnitude > 9,999,999.
REQ-020 CONV SHALL run exactly 28 cycles of shift-and-add-3 double-dabble, producing 8 BCD digits.
REQ-021 FMT (1 cycle) SHALL register all output vectors simultaneously.
REQ-022 On the FMT edge the block SHALL also set done=1, clear busy and return to IDLE.
REQ-023 Latency: done SHALL be high in the 31st cycle after the load edge.
REQ-024 Outputs SHALL be stable between done pulses.
REQ-025 Leading-zero blanking: a digit SHALL be blank (code 16, enable 0) if it and all digits to its left are zero.
REQ-026 Leading-zero blanking SHALL exclude digit 1 and any digit at or right of position dp_idx+1.
REQ-027 Negative values SHALL place code 12 (enable 1) on the digit immediately left of the most significant shown digit.
REQ-028 Zero SHALL display as a single "0" on digit 1, with no minus sign, irrespective of the input sign.
REQ-029 seg_dot_en SHALL be one-hot at bit dp_idx when dp_idx != 0, and 0 otherwise.
REQ-030 err_in=1 or overflow SHALL give the error display: seg_data_1=15, enable 8'h01, other digits 16, seg_dot_en=0.
REQ-031 Overflow and error SHALL take priority over dp_idx.
REQ-032 value_in = -2^27 SHALL be treated as overflow, with no wrap.

Reset
REQ-033 On rst=1 the block SHALL set: state IDLE, busy=0, done=0, all seg_data_n=16, seg_data_en=8'h00, seg_dot_en=8'h00.
REQ-034 rst asserted mid-conversion SHALL abandon the conversion without producing a done pulse.
REQ-035 rst SHALL take priority over a simultaneous load.

Structure
REQ-036 Shared package disp_pkg SHALL hold the glyph code constants (CODE_MINUS=12, CODE_E=15, CODE_BLANK=16) and NUM_DIGITS.
REQ-037 disp_pkg SHALL be shared with the segment driver.
REQ-038 The double-dabble engine SHALL be a sub-module bin2bcd_seq with start/busy/done handshake, a 28-bit input and a 32-bit BCD output.
REQ-039 The FSM and the formatting logic SHALL live in disp_formatter.

Verification
REQ-040 Bench SHALL cover: load, value 12345678, dp_idx 0 -> done at cycle 31; digits 8..1 = 1,2,3,4,5,6,7,8; en=8'hFF; dot=8'h00.
REQ-041 Bench SHALL cover: load, value -42, dp_idx 0 -> seg1=2, seg2=4, seg3=12, en=8'h07, others 16.
REQ-042 Bench SHALL cover: load, value 5, dp_idx 2 -> seg1=5, seg2=0, seg3=0, en=8'h07, dot=8'h04 (displays "0.05").
REQ-043 Bench SHALL cover: load, value 100000000 -> error display seg1=15, en=8'h01; same result for value -10000000, and for value 7 with err_in=1.
REQ-044 Bench SHALL cover: second load during busy -> ignored, exactly one done, outputs from the first request.
REQ-045 Bench SHALL cover: rst asserted at CONV cycle 10 -> no done, outputs at reset values; a following load of 0 -> seg1=0, en=8'h01.
